video_line_buffer: RTL and testbench

- Parametrised ping-pong line buffer: a "back" bank is filled with packed pixel words while the "front" bank streams one pixel per clock to the video output.
- Generalises the single-bank row cache with configurable pixel width, packing, line length, horizontal flip, horizontal scaling (1x/2x/4x) and underrun detection.
- Sits between the VRAM/decoder fetch engines and the video output stage; whole block runs in one clock domain.

---
 rtl/video_pkg.sv | 24 ++
 rtl/video_line_ram.sv | 23 ++
 rtl/video_line_buffer.sv | 196 +++++++++++++++++++
 tb/tb_video_line_buffer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the video line buffer.
package video_pkg;

  typedef enum logic [1:0] {
    SCALE_1X   = 2'd0,
    SCALE_2X   = 2'd1,
    SCALE_4X   = 2'd2,
    SCALE_RSVD = 2'd3
  } scale_e;

  localparam int unsigned DEF_PIXEL_BITS      = 12;
  localparam int unsigned DEF_PIXELS_PER_WORD = 2;
  localparam int unsigned DEF_LINE_WORDS      = 512;

  // Pixel-counter shift for a scale code; the reserved code behaves as 1x.
  function automatic logic [1:0] scale_shift(input logic [1:0] scale);
    case (scale_e'(scale))
      SCALE_2X: scale_shift = 2'd1;
      SCALE_4X: scale_shift = 2'd2;
      default:  scale_shift = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/video_line_ram.sv
// Simple dual-port line RAM: one write port, one registered read port.
module video_line_ram #(
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] mem [0:(1 << ADDR_BITS)-1];

  // Write port and registered read port; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/video_line_buffer.sv
// Ping-pong line buffer: back bank is filled by the fetch engine while the
// front bank streams one pixel per clock with flip, scaling and underrun flag.
module video_line_buffer
  import video_pkg::*;
#(
  parameter int unsigned PIXEL_BITS      = DEF_PIXEL_BITS,
  parameter int unsigned PIXELS_PER_WORD = DEF_PIXELS_PER_WORD,
  parameter int unsigned LINE_WORDS      = DEF_LINE_WORDS,
  parameter int unsigned ADDR_BITS       = $clog2(DEF_LINE_WORDS)
) (
  input  logic                                  i_master_clk,
  input  logic                                  i_reset,
  input  logic                                  i_wr_start,
  input  logic [ADDR_BITS-1:0]                  i_wr_column,
  input  logic [PIXEL_BITS*PIXELS_PER_WORD-1:0] i_wr_data,
  input  logic                                  i_wr_valid,
  input  logic                                  i_wr_done,
  input  logic                                  i_line_swap,
  input  logic                                  i_pixel_first,
  input  logic                                  i_pixel_last,
  input  logic                                  i_blank,
  input  logic                                  i_flip,
  input  logic [1:0]                            i_scale,
  output logic [PIXEL_BITS-1:0]                 o_pixel,
  output logic                                  o_pixel_valid,
  output logic                                  o_back_ready,
  output logic                                  o_underrun
);

  localparam int unsigned WORD_BITS   = PIXEL_BITS * PIXELS_PER_WORD;
  localparam int unsigned LANE_BITS   = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;
  localparam int unsigned LINE_PIXELS = LINE_WORDS * PIXELS_PER_WORD;

  // Bank control state
  logic       front;
  logic [1:0] full;
  logic       window_open;
  logic       front_valid;
  logic       back_full;
  logic       back_full_next;

  // Read-side state, latched at the first pixel of a line
  logic        read_active;
  logic [15:0] p;
  logic        flip_l;
  logic [1:0]  scale_l;
  logic        bank_l;
  logic        line_valid;

  // Current-cycle read address terms
  logic                 active;
  logic [15:0]          cur_p;
  logic                 cur_flip;
  logic [1:0]           cur_scale;
  logic                 cur_bank;
  logic                 cur_valid;
  logic [15:0]          q;
  logic                 in_range;
  logic [ADDR_BITS-1:0] word_raw;
  logic [ADDR_BITS-1:0] word_sel;
  logic [LANE_BITS-1:0] lane_raw;
  logic [LANE_BITS-1:0] lane_sel;

  // Pipeline
  logic [LANE_BITS-1:0] lane_d1;
  logic                 show_d1;
  logic                 blank_d1;
  logic [WORD_BITS-1:0] rd_data;

  assign back_full    = full[~front];
  assign o_back_ready = ~back_full & ~window_open;

  // Back-bank full flag as seen by a same-cycle swap (wr_done applied first).
  always_comb begin
    back_full_next = back_full;
    if (i_wr_done)
      back_full_next = 1'b1;
    else if (i_wr_start)
      back_full_next = 1'b0;
  end

  // Fill window, full flags, bank swap and underrun pulse.
  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) begin
      front       <= 1'b0;
      full        <= '0;
      window_open <= 1'b0;
      front_valid <= 1'b0;
      o_underrun  <= 1'b0;
    end else begin
      o_underrun <= 1'b0;
      if (i_wr_done) begin
        window_open  <= 1'b0;
        full[~front] <= 1'b1;
      end else if (i_wr_start) begin
        window_open  <= 1'b1;
        full[~front] <= 1'b0;
      end
      if (i_line_swap) begin
        window_open <= 1'b0;
        if (back_full_next) begin
          front       <= ~front;
          full[front] <= 1'b0;
          front_valid <= 1'b1;
        end else begin
          front_valid <= 1'b0;
          o_underrun  <= 1'b1;
        end
      end
    end
  end

  // Address generation; on the first pixel the live inputs bypass the latches
  // so the first pixel reaches the output two clocks later.
  always_comb begin
    active    = i_pixel_first | read_active;
    cur_p     = i_pixel_first ? '0 : p;
    cur_flip  = i_pixel_first ? i_flip : flip_l;
    cur_scale = i_pixel_first ? i_scale : scale_l;
    cur_bank  = i_pixel_first ? front : bank_l;
    cur_valid = i_pixel_first ? front_valid : line_valid;
    q         = cur_p >> scale_shift(cur_scale);
    in_range  = 32'(q) < LINE_PIXELS;
    word_raw  = ADDR_BITS'(q / PIXELS_PER_WORD);
    lane_raw  = LANE_BITS'(q % PIXELS_PER_WORD);
    word_sel  = word_raw;
    lane_sel  = lane_raw;
    if (cur_flip) begin
      word_sel = ADDR_BITS'(LINE_WORDS - 1) - word_raw;
      lane_sel = LANE_BITS'(PIXELS_PER_WORD - 1) - lane_raw;
    end
  end

  // Pixel counter and per-line latches.
  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) begin
      read_active <= 1'b0;
      p           <= '0;
      flip_l      <= 1'b0;
      scale_l     <= '0;
      bank_l      <= 1'b0;
      line_valid  <= 1'b0;
    end else begin
      read_active <= active & ~i_pixel_last;
      if (i_pixel_first) begin
        p          <= 16'd1;
        flip_l     <= i_flip;
        scale_l    <= i_scale;
        bank_l     <= front;
        line_valid <= front_valid;
      end else if (read_active) begin
        p <= p + 16'd1;
      end
    end
  end

  video_line_ram #(
    .WIDTH     (WORD_BITS),
    .ADDR_BITS (ADDR_BITS + 1)
  ) u_ram (
    .clk     (i_master_clk),
    .wr_en   (i_wr_valid & window_open),
    .wr_addr ({~front, i_wr_column}),
    .wr_data (i_wr_data),
    .rd_addr ({cur_bank, word_sel}),
    .rd_data (rd_data)
  );

  // Stage 1: side-band travelling alongside the RAM read.
  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) begin
      lane_d1  <= '0;
      show_d1  <= 1'b0;
      blank_d1 <= 1'b0;
    end else begin
      lane_d1  <= lane_sel;
      show_d1  <= active & in_range & cur_valid;
      blank_d1 <= i_blank;
    end
  end

  // Stage 2: lane select and output masking.
  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) begin
      o_pixel       <= '0;
      o_pixel_valid <= 1'b0;
    end else begin
      o_pixel_valid <= show_d1 & ~blank_d1;
      if (show_d1 & ~blank_d1)
        o_pixel <= rd_data[lane_d1 * PIXEL_BITS +: PIXEL_BITS];
      else
        o_pixel <= '0;
    end
  end

endmodule

// File: tb/tb_video_line_buffer.sv
// Scoreboard bench for video_line_buffer with a pixel-level reference model.
module tb_video_line_buffer;

  localparam int PB   = 12;
  localparam int PPW  = 2;
  localparam int LW   = 512;
  localparam int AB   = 9;
  localparam int NPIX = LW * PPW;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_start, wr_valid, wr_done, line_swap;
  logic [AB-1:0]   wr_column;
  logic [PB*PPW-1:0] wr_data;
  logic            pixel_first, pixel_last, blank, flip;
  logic [1:0]      scale;
  logic [PB-1:0]   pixel;
  logic            pixel_valid, back_ready, underrun;

  always #5 clk = ~clk;

  video_line_buffer #(
    .PIXEL_BITS      (PB),
    .PIXELS_PER_WORD (PPW),
    .LINE_WORDS      (LW),
    .ADDR_BITS       (AB)
  ) dut (
    .i_master_clk  (clk),
    .i_reset       (rst),
    .i_wr_start    (wr_start),
    .i_wr_column   (wr_column),
    .i_wr_data     (wr_data),
    .i_wr_valid    (wr_valid),
    .i_wr_done     (wr_done),
    .i_line_swap   (line_swap),
    .i_pixel_first (pixel_first),
    .i_pixel_last  (pixel_last),
    .i_blank       (blank),
    .i_flip        (flip),
    .i_scale       (scale),
    .o_pixel       (pixel),
    .o_pixel_valid (pixel_valid),
    .o_back_ready  (back_ready),
    .o_underrun    (underrun)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [PB-1:0] pix;
    int unsigned   cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;

  // Reference model: two banks of linear pixels plus bank bookkeeping.
  logic [PB-1:0] mpix [2][NPIX];
  int m_front;
  bit m_full[2];
  bit m_window;
  bit m_fvalid;

  // Monitor: every valid output must match the head of the scoreboard.
  exp_t got_e;
  always @(negedge clk) begin
    if (mon_en) begin
      tests++;
      if (pixel_valid) begin
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pixel: got valid pixel %0d at cycle %0d, required no valid pixel", pixel, cyc);
        end else begin
          got_e = sb.pop_front();
          if (pixel !== got_e.pix || cyc != got_e.cyc) begin
            fails++;
            $display("FAIL pixel: got %0d at cycle %0d, required %0d at cycle %0d", pixel, cyc, got_e.pix, got_e.cyc);
          end
        end
      end else if (pixel !== '0) begin
        fails++;
        $display("FAIL idle_zero: got pixel %0d with valid low, required 0", pixel);
      end
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL timeout: simulation did not finish within its time bound");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  function automatic int shift_of(input logic [1:0] s);
    return (s == 2'd1) ? 1 : (s == 2'd2) ? 2 : 0;
  endfunction

  task automatic model_reset();
    m_front = 0; m_full[0] = 0; m_full[1] = 0; m_window = 0; m_fvalid = 0;
  endtask

  task automatic do_wr_start();
    wr_start = 1'b1; tick(); wr_start = 1'b0;
    m_window = 1; m_full[1 - m_front] = 0;
  endtask

  task automatic do_write(input int col, input logic [PB*PPW-1:0] data);
    wr_valid = 1'b1; wr_column = AB'(col); wr_data = data;
    tick();
    wr_valid = 1'b0;
    if (m_window)
      for (int l = 0; l < PPW; l++) mpix[1 - m_front][col * PPW + l] = data[l * PB +: PB];
  endtask

  task automatic do_wr_done();
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    m_window = 0; m_full[1 - m_front] = 1;
  endtask

  task automatic do_swap(input bit with_done);
    bit exp_u;
    line_swap = 1'b1; wr_done = with_done;
    tick();
    line_swap = 1'b0; wr_done = 1'b0;
    if (with_done) begin m_window = 0; m_full[1 - m_front] = 1; end
    exp_u = !m_full[1 - m_front];
    m_window = 0;
    if (!exp_u) begin
      m_full[m_front] = 0; m_front = 1 - m_front; m_fvalid = 1;
    end else begin
      m_fvalid = 0;
    end
    check("underrun_pulse", 32'(underrun), 32'(exp_u));
    check("back_ready_after_swap", 32'(back_ready), 32'(!m_full[1 - m_front] && !m_window));
    tick();
    check("underrun_clear", 32'(underrun), 0);
  endtask

  task automatic fill(input bit pattern);
    int order[LW];
    for (int i = 0; i < LW; i++) order[i] = i;
    if (!pattern)
      for (int i = LW - 1; i > 0; i--) begin
        int j; int t;
        j = $urandom_range(i, 0); t = order[i]; order[i] = order[j]; order[j] = t;
      end
    // Writes while the window is closed must be dropped.
    for (int k = 0; k < 4; k++) do_write($urandom_range(LW - 1, 0), $urandom);
    do_wr_start();
    check("back_ready_window", 32'(back_ready), 0);
    for (int i = 0; i < LW; i++) begin
      int n;
      n = order[i];
      if (pattern) do_write(n, {PB'(2 * n + 1), PB'(2 * n)});
      else do_write(n, $urandom);
    end
  endtask

  // Drives one line; reset_at >= 0 asserts reset at that pixel instead.
  task automatic run_line(input int n_pix, input bit lflip, input logic [1:0] lscale,
                          input int blank_pct, input int reset_at);
    int lfront; bit lvalid; int sh;
    lfront = m_front; lvalid = m_fvalid; sh = shift_of(lscale);
    for (int pi = 0; pi < n_pix; pi++) begin
      if (pi == reset_at) begin
        mon_en = 1'b0;
        rst = 1'b1;
        pixel_first = 1'b0; pixel_last = 1'b0; blank = 1'b0;
        #1;
        check("reset_pixel", 32'(pixel), 0);
        check("reset_valid", 32'(pixel_valid), 0);
        check("reset_underrun", 32'(underrun), 0);
        sb.delete();
        model_reset();
        return;
      end
      pixel_first = (pi == 0);
      pixel_last  = (pi == n_pix - 1);
      flip        = (pi == 0) ? lflip : 1'($urandom);
      scale       = (pi == 0) ? lscale : 2'($urandom);
      blank       = ($urandom_range(99, 0) < blank_pct);
      if (lvalid && !blank) begin
        int q;
        q = pi >> sh;
        if (q < NPIX) begin
          exp_t e;
          e.pix = mpix[lfront][lflip ? NPIX - 1 - q : q];
          e.cyc = cyc + 2;
          sb.push_back(e);
        end
      end
      tick();
    end
    pixel_first = 1'b0; pixel_last = 1'b0; blank = 1'b0; flip = 1'b0; scale = 2'd0;
    repeat (4) tick();
    check("line_drained", 32'(sb.size()), 0);
    sb.delete();
  endtask

  initial begin
    rst = 1'b1;
    wr_start = 0; wr_valid = 0; wr_done = 0; line_swap = 0; wr_column = '0; wr_data = '0;
    pixel_first = 0; pixel_last = 0; blank = 0; flip = 0; scale = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_pixel", 32'(pixel), 0);
    check("rst_valid", 32'(pixel_valid), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_back_ready", 32'(back_ready), 1);
    rst = 1'b0;
    tick();
    mon_en = 1'b1;

    // Counting pattern: straight, mirrored, 2x scaled with out-of-range tail.
    fill(1'b1);
    do_wr_done();
    check("back_ready_full", 32'(back_ready), 0);
    do_swap(1'b0);
    run_line(NPIX, 1'b0, 2'd0, 0, -1);
    run_line(NPIX, 1'b1, 2'd0, 0, -1);
    run_line(2100, 1'b0, 2'd1, 0, -1);

    // Random content, geometry and blanking.
    for (int it = 0; it < 3; it++) begin
      fill(1'b0);
      do_wr_done();
      do_swap(1'b0);
      run_line($urandom_range(1400, 600), 1'($urandom), 2'($urandom), 20, -1);
    end
    run_line(3000, 1'b1, 2'd2, 10, -1);

    // Swap during an open window: underrun, then a dead line.
    do_wr_start();
    for (int k = 0; k < 8; k++) do_write(k, $urandom);
    check("back_ready_open", 32'(back_ready), 0);
    do_swap(1'b0);
    run_line(300, 1'b0, 2'd0, 0, -1);

    // wr_done together with swap: no underrun, fresh data shown.
    fill(1'b0);
    do_swap(1'b1);
    run_line(NPIX, 1'($urandom), 2'd0, 10, -1);

    // Reset in the middle of a line.
    run_line(NPIX, 1'b0, 2'd0, 0, 40);
    tick(); tick();
    rst = 1'b0;
    tick();
    mon_en = 1'b1;
    check("post_rst_back_ready", 32'(back_ready), 1);
    check("post_rst_underrun", 32'(underrun), 0);
    do_swap(1'b0);
    run_line(200, 1'b0, 2'd0, 0, -1);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
